// File: rtl/uart_transmitter.sv
// uart_transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the PARITY state and the PARITY_ODD parameter.
module uart_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baudTick,
  input  logic                  txStart,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  txReady,
  output logic                  tx,
  output logic                  txDone
);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
  endgenerate
  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif
  assign bit_end = baudTick && tick_q == TW'(OVERSAMPLE - 1);
  assign txReady = state_q == IDLE;
  assign tx      = tx_q;
  assign txDone  = done_q;
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE && baudTick) tick_d = bit_end ? '0 : tick_q + TW'(1);
    case (state_q)
      IDLE: if (txStart) begin
        state_d = START;
        shift_d = dataIn;
        tick_d  = '0;
        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^dataIn ^ PARITY_ODD;
`endif
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d = bit_q + BW'(1);
          tx_d  = shift_d[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        stop_d  = 1'b0;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (stop_q == 1'(STOP_BITS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: queue scoreboard with a per-cycle line monitor against a frame-level model.
module tb_uart_transmitter;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  localparam bit ODD = 1'b0;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + DW + P + SB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baudTick = 1'b0;
  logic txStart = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic txReady, tx, txDone;
  int checks = 0;
  int failures = 0;
  int sent = 0;
  int framed = 0;
  int dones = 0;
  int tick_mode = 0;
  logic [DW-1:0] exp_q[$];
  uart_transmitter #(
    .DATA_WIDTH(DW), .OVERSAMPLE(OS), .STOP_BITS(SB)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(ODD)
`endif
  ) dut (
    .clk(clk), .rst(rst), .baudTick(baudTick), .txStart(txStart),
    .dataIn(dataIn), .txReady(txReady), .tx(tx), .txDone(txDone)
  );
  always #5 clk = ~clk;
  function automatic logic frame_bit(logic [DW-1:0] d, int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return d[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == DW + 1) return ^d ^ ODD;
`endif
    return 1'b1;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    baudTick = tick_mode == 0 ? 1'b1 : tick_mode == 1 ? ($urandom_range(0, 3) == 0) : 1'b0;
  end
  initial forever begin
    @(negedge clk);
    if (txDone) dones++;
  end
  initial begin : monitor
    int n;
    bit active;
    logic t;
    logic [DW-1:0] cur;
    n = 0;
    active = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      t = baudTick;
      @(negedge clk);
      if (rst) active = 0;
      else if (active) begin
        if (t) n++;
        if (n == NB * OS) begin
          check("done_pulse", txDone, 1);
          check("ready_at_done", txReady, 1);
          check("tx_at_done", tx, 1);
          active = 0;
          framed++;
        end else begin
          check("tx_bit", tx, frame_bit(cur, n / OS));
          check("done_early", txDone, 0);
          check("ready_busy", txReady, 0);
        end
      end else begin
        check("done_idle", txDone, 0);
        if (tx === 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame: got start bit expected idle at %0t", $time);
            cur = '0;
          end else cur = exp_q.pop_front();
          active = 1;
          n = 0;
        end
      end
    end
  end
  task automatic send(logic [DW-1:0] d);
    int w;
    w = 0;
    while (!txReady && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", txReady, 1);
    if (!txReady) return;
    txStart = 1'b1;
    dataIn = d;
    @(posedge clk);
    exp_q.push_back(d);
    sent++;
    @(negedge clk);
    txStart = 1'b0;
    dataIn = DW'($urandom);
    check("start_latency", tx, 0);
    check("ready_drop", txReady, 0);
  endtask
  task automatic wait_idle();
    int w;
    w = 0;
    while (framed < sent && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("frame_timeout", framed, sent);
  endtask
  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", txReady, 1);
    check("reset_done", txDone, 0);
    rst = 1'b0;
    @(negedge clk);
    send(8'hA5);
    wait_idle();
    send(8'h3C);
    repeat (40) @(negedge clk);
    txStart = 1'b1;
    dataIn = 8'hFF;
    @(negedge clk);
    txStart = 1'b0;
    wait_idle();
    send(8'h00);
    w = 0;
    while (!txDone && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("b2b_done_seen", txDone, 1);
    send(8'hFF);
    wait_idle();
    send(8'h07);
    send(8'h03);
    wait_idle();
    send(8'h5A);
    repeat (50) @(negedge clk);
    tick_mode = 2;
    repeat (100) @(negedge clk);
    tick_mode = 0;
    wait_idle();
    tick_mode = 1;
    for (int i = 0; i < 10; i++) send(DW'($urandom));
    wait_idle();
    tick_mode = 0;
    @(negedge clk);
    send(8'hA5);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_ready", txReady, 1);
    check("async_reset_done", txDone, 0);
    sent--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_tx", tx, 1);
    check("queue_empty", exp_q.size(), 0);
    check("frame_count", framed, sent);
    check("done_count", dones, framed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises parallel bytes onto a UART line: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s). It is the upstream counterpart of uart_receiver; its tx output drives the receiver's rx line. Bit timing comes from the shared uart_baudRateGen tick. A one-entry accept handshake lets a host or bus-side controller queue exactly one byte per frame.

Parameters:
DATA_WIDTH, 8, data bits per frame.
OVERSAMPLE, 16, baudTick pulses per bit period, matched to uart_baudRateGen.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2, anything else is an elaboration error.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
baudTick  input  1  single-cycle oversample tick from uart_baudRateGen.
txStart  input  1  request to send dataIn; sampled only while txReady=1.
dataIn  input  DATA_WIDTH  byte to send; captured on accept.
txReady  output  1  high when idle and able to accept.
tx  output  1  serial line, registered, idle high.
txDone  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - tx=1, txReady=1, txDone=0.
  - Counters and the shift register clear to 0.
  - Reset mid-frame aborts the frame immediately; tx returns high without waiting for clk.
- Accept: on a clk edge with state IDLE and txStart=1:
  - dataIn is latched into shiftReg.
  - State moves to START, tickCnt=0.
  - In that same edge tx is driven to 0 and txReady to 0.
  - Latency from txStart sample to tx falling edge is 1 clk.
- Busy: while txReady=0, txStart is ignored and dataIn changes have no effect.
- Counters:
  - tickCnt (width clog2(OVERSAMPLE)) increments only on clk edges with baudTick=1.
  - When tickCnt reaches OVERSAMPLE-1 with baudTick=1, the current bit ends: tickCnt wraps to 0 and the next bit is driven on the same edge.
  - Each bit therefore lasts exactly OVERSAMPLE baudTicks.
  - The start bit's first tick is the first baudTick after accept.
- States:
  - IDLE: tx=1.
  - START: tx=0; after one bit, go to DATA with bitCnt=0 and tx=shiftReg[0].
  - DATA: tx=shiftReg[0]. At each bit end, shift right and increment bitCnt. When bitCnt reaches DATA_WIDTH-1, go to PARITY if enabled, else STOP.
  - PARITY: tx is the parity bit; after one bit, go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods, then return to IDLE.
- On the STOP exit edge:
  - txDone=1 for exactly one clk.
  - txReady=1 on that same edge.
  - A txStart on the following edge starts the next frame back-to-back with no extra idle bit.
- baudTick held constantly high: legal; each bit lasts OVERSAMPLE clks.
- baudTick stuck low: the transmitter stays in its current bit indefinitely; no timeout.
- Simultaneous rst and txStart: reset wins.
- Frame length in baudTicks is OVERSAMPLE*(1+DATA_WIDTH+P+STOP_BITS), where P=1 if parity is enabled, else 0.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is present.
  - Parameter PARITY_ODD (default 0) is added.
  - Parity bit = XOR of the latched data, XOR PARITY_ODD (even parity by default).
  - The parity bit is computed at accept from the latched byte.
- Undefined: no PARITY state, no PARITY_ODD parameter, and DATA goes directly to STOP.

Test Plan:
- Reset: assert rst mid-DATA with dataIn=8'hA5 in flight -> tx=1, txReady=1 and txDone=0 at once, before the next clk edge. After release, tx stays 1 with no spurious txDone.
- Single frame: OVERSAMPLE=16, baudTick every clk, send 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 16 clks. txDone pulses once at clk 160 after accept.
- Busy ignore: send 8'h3C, then pulse txStart with dataIn=8'hFF during DATA -> the line carries only 8'h3C and exactly one txDone pulse occurs.
- Back-to-back: assert txStart on the txDone edge with 8'h00, then 8'hFF -> the second start bit immediately follows the stop bit, with no extra idle period.
- Loopback: drive tx into uart_receiver at 19200 baud with the real uart_baudRateGen and send 10 random bytes -> the receiver's dataOut matches each byte, with one new_byte_indicate per byte.
- Parity (UART_TX_PARITY_EN): send 8'h07 with PARITY_ODD=0 -> parity bit 1. Send 8'h03 -> parity bit 0. With PARITY_ODD=1 both results invert.
